// File: rtl/ram_arbiter.sv
// Two-port (fetch/load-store) arbiter sharing one single-port byte-lane RAM.
// Define RAM_ARB_DPRIO_EN for fixed data-port priority instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 262144
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_sel,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_sel,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam logic [ADDR_WIDTH:0] LP_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t                  r_state;
  state_t                  w_nextState;
  port_t                   r_owner;
  port_t                   r_lastGrant;
  logic                    r_errQ;
  logic [DATA_WIDTH-1:0]   r_iRdata;
  logic [DATA_WIDTH-1:0]   r_dRdata;
  logic                    w_anyReq;
  logic                    w_grantD;
  logic [ADDR_WIDTH-1:0]   w_grantAddr;

  assign w_anyReq = i_req | d_req;

`ifdef RAM_ARB_DPRIO_EN
  assign w_grantD = d_req;
`else
  // Under contention the port that did not win last time gets the grant.
  assign w_grantD = d_req & (~i_req | (r_lastGrant == PORT_I));
`endif

  assign w_grantAddr = w_grantD ? d_addr : i_addr;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_anyReq) w_nextState = ST_ACCESS;
      ST_ACCESS: w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= PORT_I;
      r_lastGrant <= PORT_D;
      r_errQ      <= 1'b0;
      r_iRdata    <= '0;
      r_dRdata    <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && w_anyReq) begin
        r_owner     <= w_grantD ? PORT_D : PORT_I;
        r_lastGrant <= w_grantD ? PORT_D : PORT_I;
        r_errQ      <= ({1'b0, w_grantAddr} >= LP_LIMIT);
      end
      // Read data is captured only for in-range reads; write acks keep the old value.
      if (r_state == ST_ACCESS && !r_errQ) begin
        if (r_owner == PORT_I) r_iRdata <= ram_rdata;
        else if (!d_we)        r_dRdata <= ram_rdata;
      end
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    i_ack     = 1'b0;
    i_err     = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        // Reset during the access cycle must suppress the RAM write.
        if (!r_errQ) begin
          ram_en = rst_n;
          if (r_owner == PORT_D) begin
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_sel   = d_sel;
            ram_wdata = d_wdata;
          end else begin
            ram_addr = i_addr;
            ram_sel  = '1;
          end
        end
      end
      ST_DONE: begin
        if (r_owner == PORT_I) begin
          i_ack = 1'b1;
          i_err = r_errQ;
        end else begin
          d_ack = 1'b1;
          d_err = r_errQ;
        end
      end
      default: ;
    endcase
  end

  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM.
// Contention expectations follow RAM_ARB_DPRIO_EN when it is defined.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        loadMem;
  logic [31:0] mem [0:255];
  int          checkCount = 0;
  int          errCount = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[9:2]];

  // Behavioural RAM: preload known words, then honour byte-lane writes.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int w = 0; w < 256; w++) mem[w] <= 32'h0;
      mem[0]    <= 32'h0BADF00D;
      mem[2]    <= 32'hCAFEF00D;
      mem[8]    <= 32'h11223344;
      mem[8'h40] <= 32'hDEADBEEF;
    end else if (ram_en && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isD, input bit we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] wdata);
    if (isD) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_sel = sel; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
  endtask

  task automatic releaseReq();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; loadMem = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_sel = 0; d_wdata = 0;
    tick();
    tick();
    loadMem = 1'b0;
    checkOutput("rst_i_ack", 32'(i_ack), 0);
    checkOutput("rst_d_ack", 32'(d_ack), 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_ram_en", 32'(ram_en), 0);
    rst_n = 1'b1;
    tick();

    // Single fetch read
    applyStimulus(0, 0, 32'h100, 4'h0, 32'h0);
    tick();
    checkOutput("rd_ram_en", 32'(ram_en), 1);
    checkOutput("rd_ram_we", 32'(ram_we), 0);
    checkOutput("rd_ram_addr", ram_addr, 32'h100);
    checkOutput("rd_ram_sel", 32'(ram_sel), 32'hF);
    checkOutput("rd_i_ack_early", 32'(i_ack), 0);
    tick();
    checkOutput("rd_i_ack", 32'(i_ack), 1);
    checkOutput("rd_i_rdata", i_rdata, 32'hDEADBEEF);
    checkOutput("rd_i_err", 32'(i_err), 0);
    checkOutput("rd_d_ack", 32'(d_ack), 0);
    releaseReq();
    tick();
    checkOutput("rd_ram_en_after", 32'(ram_en), 0);

    // Held fetch request produces a second grant three cycles later
    applyStimulus(0, 0, 32'h100, 4'h0, 32'h0);
    tick();
    tick();
    checkOutput("held_ack1", 32'(i_ack), 1);
    tick();
    checkOutput("held_gap", 32'(i_ack), 0);
    tick();
    checkOutput("held_ram_en", 32'(ram_en), 1);
    checkOutput("held_no_ack", 32'(i_ack), 0);
    tick();
    checkOutput("held_ack2", 32'(i_ack), 1);
    releaseReq();
    tick();

    // Byte-lane write, then read back the merged word
    applyStimulus(1, 1, 32'h20, 4'b0010, 32'h0000AB00);
    tick();
    checkOutput("wr_ram_en", 32'(ram_en), 1);
    checkOutput("wr_ram_we", 32'(ram_we), 1);
    checkOutput("wr_ram_sel", 32'(ram_sel), 32'h2);
    checkOutput("wr_ram_wdata", ram_wdata, 32'h0000AB00);
    tick();
    checkOutput("wr_d_ack", 32'(d_ack), 1);
    checkOutput("wr_d_err", 32'(d_err), 0);
    checkOutput("wr_d_rdata_held", d_rdata, 0);
    releaseReq();
    tick();
    applyStimulus(1, 0, 32'h20, 4'h0, 32'h0);
    tick();
    tick();
    checkOutput("rdback_d_ack", 32'(d_ack), 1);
    checkOutput("rdback_d_rdata", d_rdata, 32'h1122AB44);
    releaseReq();
    tick();

    // Write with no byte lanes selected
    applyStimulus(1, 1, 32'h20, 4'h0, 32'hFFFFFFFF);
    tick();
    checkOutput("sel0_ram_en", 32'(ram_en), 1);
    checkOutput("sel0_ram_we", 32'(ram_we), 1);
    checkOutput("sel0_ram_sel", 32'(ram_sel), 0);
    tick();
    checkOutput("sel0_d_ack", 32'(d_ack), 1);
    checkOutput("sel0_d_err", 32'(d_err), 0);
    releaseReq();
    tick();

    // Out-of-range write never reaches the RAM
    applyStimulus(1, 1, 32'h40000, 4'hF, 32'hFFFFFFFF);
    tick();
    checkOutput("oor_ram_en_c1", 32'(ram_en), 0);
    tick();
    checkOutput("oor_ram_en_c2", 32'(ram_en), 0);
    checkOutput("oor_d_ack", 32'(d_ack), 1);
    checkOutput("oor_d_err", 32'(d_err), 1);
    checkOutput("oor_d_rdata_held", d_rdata, 32'h1122AB44);
    releaseReq();
    tick();
    applyStimulus(1, 0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    checkOutput("oor_mem0", d_rdata, 32'h0BADF00D);
    checkOutput("oor_rd_err", 32'(d_err), 0);
    releaseReq();
    tick();

    // Reset asserted during the ACCESS cycle of a write
    applyStimulus(1, 1, 32'h8, 4'hF, 32'h55555555);
    tick();
    checkOutput("rstacc_ram_en_pre", 32'(ram_en), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstacc_ram_en_gated", 32'(ram_en), 0);
    tick();
    checkOutput("rstacc_d_ack", 32'(d_ack), 0);
    checkOutput("rstacc_d_rdata", d_rdata, 0);
    checkOutput("rstacc_i_rdata", i_rdata, 0);
    checkOutput("rstacc_ram_en", 32'(ram_en), 0);
    releaseReq();
    rst_n = 1'b1;
    tick();
    applyStimulus(1, 0, 32'h8, 4'h0, 32'h0);
    tick();
    tick();
    checkOutput("rstacc_rdback", d_rdata, 32'hCAFEF00D);
    releaseReq();
    tick();

    // Contention from a fresh reset: both ports held for 12 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_sel = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef RAM_ARB_DPRIO_EN
      checkOutput($sformatf("cont_i_ack_%0d", k), 32'(i_ack), 0);
      checkOutput($sformatf("cont_d_ack_%0d", k), 32'(d_ack), (k % 3 == 2) ? 1 : 0);
`else
      checkOutput($sformatf("cont_i_ack_%0d", k), 32'(i_ack),
                  (k == 2 || k == 8) ? 1 : 0);
      checkOutput($sformatf("cont_d_ack_%0d", k), 32'(d_ack),
                  (k == 5 || k == 11) ? 1 : 0);
`endif
    end
`ifdef RAM_ARB_DPRIO_EN
    checkOutput("cont_i_rdata", i_rdata, 0);
`else
    checkOutput("cont_i_rdata", i_rdata, 32'hDEADBEEF);
`endif
    checkOutput("cont_d_rdata", d_rdata, 32'h1122AB44);
    releaseReq();
    tick();
    tick();
    checkOutput("cont_idle_ram_en", 32'(ram_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter that shares the single-port byte-lane data RAM between the instruction-fetch port (I) and the load/store port (D).
- Each requester uses a req/ack handshake. The arbiter serializes accesses and drives the RAM enable, write-enable, address, byte-select and write-data.
- It captures the RAM's combinational read data into a per-port response register.
- Sits between the CPU fetch/MEM stages and the RAM; out-of-range addresses get an error response and never reach the RAM.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of data buses; the byte-select width is DATA_WIDTH/8.
- MEM_BYTES, 262144, size of the valid address space in bytes; an address >= MEM_BYTES is an error.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_req  input  1  fetch request; held with i_addr stable until i_ack.
- i_addr  input  ADDR_WIDTH  fetch byte address; always a read.
- i_ack  output  1  one-cycle completion pulse for the fetch port.
- i_rdata  output  DATA_WIDTH  fetch read data; valid while i_ack=1 and held until the next I completion.
- i_err  output  1  high with i_ack when i_addr was out of range.
- d_req  input  1  data request; held with d_we/d_addr/d_sel/d_wdata stable until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_WIDTH  data byte address.
- d_sel  input  DATA_WIDTH/8  byte-lane select for writes.
- d_wdata  input  DATA_WIDTH  write data.
- d_ack  output  1  one-cycle completion pulse for the data port.
- d_rdata  output  DATA_WIDTH  load data; valid with d_ack and held.
- d_err  output  1  high with d_ack on an out-of-range access.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write-enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_sel  output  DATA_WIDTH/8  RAM byte select.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, owner=I, last_grant=D, err_q=0.
  - i_ack/d_ack/i_err/d_err=0, i_rdata=d_rdata=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: grant that port.
  - Both req: grant the port != last_grant (round-robin).
  - On grant: latch owner, set last_grant=owner, latch err_q=(owner addr >= MEM_BYTES), go to ACCESS.
- ACCESS (exactly 1 cycle), with err_q=0:
  - ram_en=rst_n.
  - ram_we = d_we if owner=D, else 0.
  - ram_addr/ram_sel/ram_wdata come from the owner's inputs; I forces ram_sel=all ones and ram_wdata=0.
  - On a read, capture ram_rdata into the owner's rdata register at the ACCESS->DONE edge.
  - Go to DONE.
- ACCESS with err_q=1:
  - ram_en=0 and rdata is unchanged.
  - Go to DONE.
- DONE (1 cycle):
  - Owner's ack=1; owner's err=err_q; the other port's ack=0.
  - Go to IDLE unconditionally; req is ignored in DONE.
- RAM outputs outside ACCESS: ram_en=ram_we=0; ram_addr/ram_sel/ram_wdata=0.
- Latency:
  - req high in cycle 0 (arbiter IDLE) -> RAM driven in cycle 1 -> ack in cycle 2.
  - Throughput is one access per 3 cycles.
  - With both ports continuously requesting, grants strictly alternate.
- Handshake rules:
  - The requester drops or changes req/payload only after the cycle in which it sees ack.
  - If req is still high in the cycle after ack, that is a new request.
  - Payload changes while a request is pending are a protocol violation; behaviour is undefined and not checked.
- Write with d_sel=0: goes through ACCESS with ram_en=1 and ram_we=1 (the RAM writes no bytes), then acks normally with err=0.
- Write acks: rdata is not updated.
- Reset mid-operation:
  - A reset in ACCESS blocks the RAM write (ram_en is gated by rst_n).
  - The in-flight request is dropped with no ack; the requester re-issues it.
- Simultaneous arrival: both reqs first rising in the same IDLE cycle after reset -> I wins, because last_grant resets to D.

Optional Feature:
- Macro: RAM_ARB_DPRIO_EN.
- Defined: fixed priority; D always wins when both ports request; last_grant is still updated but ignored. I can starve under continuous D traffic; this is accepted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single read: after reset, I reads addr 0x100 (RAM word=0xDEADBEEF) -> ram_en=1 and ram_addr=0x100 in cycle 1; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 in cycle 2.
- Byte write then read: D writes addr 0x20, sel=4'b0010, wdata=0x0000AB00, then D reads 0x20 (word was 0x11223344) -> d_rdata=0x1122AB44.
- Contention: both req held continuously for 12 cycles -> ack order I,D,I,D, one ack every 3 cycles. With RAM_ARB_DPRIO_EN defined -> D,D,D,D and i_ack never asserts.
- Out of range: D write to 0x40000 -> ram_en stays 0 throughout; d_ack=1 and d_err=1 in cycle 2; RAM contents unchanged.
- Reset in ACCESS: D write to 0x8, sel=4'hF, rst_n=0 during the ACCESS cycle -> no RAM write (a later read returns the old value); no d_ack; outputs at reset values.
- Held req: I keeps i_req high after i_ack -> a second grant is issued, with the next i_ack 3 cycles after the first.
